pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the fetch stage. Drives PC_IN and control of the PC register
//  each cycle: sequential fetch (pc+4), branch/jump/jr redirect, or hold on hazard stall.
//  Sequences the post-reset boot fetch and IF/ID flush bubbles after a redirect.
//  Sits between ID/EX hazard and branch logic and the PC register.
// PARAMETERS
//  RESET_VECTOR   32'h0000_0000  address fetched first after reset release
//  FLUSH_BUBBLES  1              cycles flush_ifid stays high per redirect (1..7)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  pc_cur         in   32  current PC register output (PC_out)
//  stall          in   1   load-use / memory hazard: hold PC
//  br_taken       in   1   resolved conditional branch taken
//  br_target      in   32  branch target address
//  jump           in   1   J/JAL taken
//  jump_target    in   32  jump target address
//  jr             in   1   JR taken
//  jr_target      in   32  register target address
//  pc_next        out  32  to PC_IN
//  pc_hold        out  1   to PC control: 0 = load pc_next, 1 = hold
//  flush_ifid     out  1   squash instruction in IF/ID
//  misalign_err   out  1   sticky: a redirect target had [1:0] != 0
//  seq_state      out  2   FSM state, for debug/trace
// BEHAVIOUR
//  - Reset (rst_n=0, async): state BOOT, pc_next=RESET_VECTOR, pc_hold=1, flush_ifid=1,
//    misalign_err=0, bubble counter=0. Outputs hold these values until release.
//  - FSM states: BOOT, RUN, FLUSH. All outputs are combinational from state + inputs.
//  - BOOT: one cycle after release. pc_next=RESET_VECTOR, pc_hold=0, flush_ifid=1.
//    Inputs ignored. -> RUN (FLUSH_BUBBLES ignored for boot).
//  - RUN priority, highest first: jr > jump > br_taken > stall > sequential.
//    redirect: pc_next = target with [1:0] forced to 2'b00, pc_hold=0, flush_ifid=1;
//      counter loads FLUSH_BUBBLES-1; -> FLUSH if that is >0, else stay RUN.
//    stall (no redirect): pc_next=pc_cur, pc_hold=1, flush_ifid=0.
//    otherwise: pc_next=pc_cur+32'd4 (mod 2^32; 32'hFFFF_FFFC -> 0), pc_hold=0.
//  - Redirect and stall in same cycle: redirect wins, stall is dropped (stalled
//    instruction is on the squashed path).
//  - FLUSH: flush_ifid=1; counter decrements each cycle; -> RUN when it reaches 0.
//    PC still advances per RUN rules (stall honoured). A new redirect in FLUSH is
//    taken and reloads the counter.
//  - misalign_err: set on the edge after any accepted redirect whose target[1:0]!=0;
//    cleared only by reset.
//  - Latency: redirect/stall act on the PC at the next rising edge (0-cycle decision,
//    1-cycle PC update). Sequential fetch rate: one PC per cycle.
//  - Reset asserted mid-FLUSH or mid-stall: immediate return to reset values; no
//    pending redirect survives.
// STRUCTURE
//  - Package pc_seq_pkg: state enum {BOOT, RUN, FLUSH} as 2-bit localparams, PC_INC=4,
//    ALIGN_MASK=32'hFFFF_FFFC, default RESET_VECTOR.
//  - Sub-module pc_next_mux: combinational priority select of pc_next and redirect flag
//    from pc_cur/targets/enables. FSM, counter and sticky error live in pc_sequencer.
// TESTING
//  - Reset/boot: RESET_VECTOR=32'h0000_0100, release rst_n -> BOOT cycle
//    pc_next=0x100, pc_hold=0, flush=1; then pc_cur=0x100 gives pc_next=0x104.
//  - Stall: pc_cur=0x200, stall=1 for 3 cycles -> pc_hold=1, pc_next=0x200 each cycle;
//    stall=0 -> pc_next=0x204.
//  - Priority: jr=1 (0x40), jump=1 (0x80), br_taken=1 (0xC0), stall=1 same cycle
//    -> pc_next=0x40, pc_hold=0, flush=1.
//  - Bubbles: FLUSH_BUBBLES=3, br_taken to 0x1000 -> flush_ifid high 3 cycles, state
//    RUN->FLUSH->FLUSH->RUN; second branch in cycle 2 restarts 3-cycle count.
//  - Wrap/misalign: pc_cur=0xFFFF_FFFC -> pc_next=0; jump_target=0x0000_0013 ->
//    pc_next=0x10, misalign_err=1 and stays 1 until rst_n=0.
//  - Async reset mid-FLUSH: drop rst_n between clk edges -> outputs go to reset values
//    immediately, state BOOT.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          CNT_W            = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic        hold;
    logic        redirect;
    logic        misalign;
  } mux_out_t;
endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// Priority select of the next fetch address: jr > jump > branch > stall > pc+4.
module pc_next_mux
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output mux_out_t    mux_o
);
  logic [31:0] tgt;

  always_comb begin
    tgt            = 32'd0;
    mux_o.pc       = pc_cur + PC_INC;
    mux_o.hold     = 1'b0;
    mux_o.redirect = 1'b0;
    if (jr)            tgt = jr_target;
    else if (jump)     tgt = jump_target;
    else if (br_taken) tgt = br_target;
    if (jr || jump || br_taken) begin
      // A redirect squashes the stalled instruction, so stall is dropped here.
      mux_o.pc       = tgt & ALIGN_MASK;
      mux_o.redirect = 1'b1;
    end else if (stall) begin
      mux_o.pc   = pc_cur;
      mux_o.hold = 1'b1;
    end
    mux_o.misalign = mux_o.redirect && (tgt[1:0] != 2'b00);
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: boot fetch, redirect with IF/ID flush bubbles, stall hold.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = DEF_RESET_VECTOR,
  parameter int          FLUSH_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        flush_ifid,
  output logic        misalign_err,
  output logic [1:0]  seq_state
);
  localparam logic [CNT_W-1:0] BUB_RELOAD = CNT_W'(FLUSH_BUBBLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  mux_out_t         mux;

  pc_next_mux u_mux (
    .pc_cur      (pc_cur),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .mux_o       (mux)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pc_next    = mux.pc;
    pc_hold    = mux.hold;
    flush_ifid = 1'b0;
    case (state_q)
      ST_RUN, ST_FLUSH: begin
        flush_ifid = (state_q == ST_FLUSH) || mux.redirect;
        if (mux.redirect) begin
          cnt_d   = BUB_RELOAD;
          state_d = (BUB_RELOAD != '0) ? ST_FLUSH : ST_RUN;
          if (mux.misalign) err_d = 1'b1;
        end else if (state_q == ST_FLUSH) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q <= 1) ? ST_RUN : ST_FLUSH;
        end
      end
      default: begin
        // Boot fetch: inputs are ignored and the bubble count does not apply.
        pc_next    = RESET_VECTOR;
        pc_hold    = 1'b0;
        flush_ifid = 1'b1;
        cnt_d      = '0;
        state_d    = ST_RUN;
      end
    endcase
    // While reset is held the PC register must stay frozen on the reset vector.
    if (!rst_n) begin
      pc_next    = RESET_VECTOR;
      pc_hold    = 1'b1;
      flush_ifid = 1'b1;
    end
  end

  assign misalign_err = err_q;
  assign seq_state    = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expectations queued at drive time, checked at negedge.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur, br_target, jump_target, jr_target;
  logic        stall, br_taken, jump, jr;
  logic [31:0] pc_next;
  logic        pc_hold, flush_ifid, misalign_err;
  logic [1:0]  seq_state;

  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        hold;
    logic        flush;
    logic        err;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0100), .FLUSH_BUBBLES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_cur       (pc_cur),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc_next      (pc_next),
    .pc_hold      (pc_hold),
    .flush_ifid   (flush_ifid),
    .misalign_err (misalign_err),
    .seq_state    (seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".pc"},    pc_next,              e.pc);
    chk({e.tag, ".hold"},  {31'd0, pc_hold},     {31'd0, e.hold});
    chk({e.tag, ".flush"}, {31'd0, flush_ifid},  {31'd0, e.flush});
    chk({e.tag, ".err"},   {31'd0, misalign_err},{31'd0, e.err});
    chk({e.tag, ".st"},    {30'd0, seq_state},   {30'd0, e.st});
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk_all(exp_q.pop_front());
  end

  // Drive one cycle's inputs (called at posedge+1) and queue the expected outputs.
  task automatic step(input string tag, input logic [31:0] pc, input logic st, input logic br,
                      input logic jp, input logic r, input logic [31:0] e_pc, input logic e_hold,
                      input logic e_flush, input logic e_err, input logic [1:0] e_st);
    exp_t e;
    pc_cur = pc; stall = st; br_taken = br; jump = jp; jr = r;
    e.tag = tag; e.pc = e_pc; e.hold = e_hold; e.flush = e_flush; e.err = e_err; e.st = e_st;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    exp_t e;
    e.tag = tag; e.pc = 32'h100; e.hold = 1'b1; e.flush = 1'b1; e.err = 1'b0; e.st = S_BOOT;
    chk_all(e);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; pc_cur = 32'h0; stall = 0; br_taken = 0; jump = 0; jr = 0;
    br_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset("rst");
    rst_n = 1'b1;

    //    tag        pc_cur         st br jp jr  exp_pc         hold fl err state
    step("boot",     32'h0000_0555, 1, 1, 1, 1,  32'h0000_0100, 0,   1, 0,  S_BOOT);
    step("seq0",     32'h0000_0100, 0, 0, 0, 0,  32'h0000_0104, 0,   0, 0,  S_RUN);
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 32'h200, 1, 0, 0, 0, 32'h0000_0200, 1, 0, 0, S_RUN);
    step("unstall",  32'h0000_0200, 0, 0, 0, 0,  32'h0000_0204, 0,   0, 0,  S_RUN);

    jr_target = 32'h40; jump_target = 32'h80; br_target = 32'hC0;
    step("prio",     32'h0000_0204, 1, 1, 1, 1,  32'h0000_0040, 0,   1, 0,  S_RUN);
    step("pfl1",     32'h0000_0040, 0, 0, 0, 0,  32'h0000_0044, 0,   1, 0,  S_FLUSH);
    step("pfl2",     32'h0000_0044, 1, 0, 0, 0,  32'h0000_0044, 1,   1, 0,  S_FLUSH);
    step("prun",     32'h0000_0044, 0, 0, 0, 0,  32'h0000_0048, 0,   0, 0,  S_RUN);

    br_target = 32'h1000;
    step("br1",      32'h0000_0048, 0, 1, 0, 0,  32'h0000_1000, 0,   1, 0,  S_RUN);
    step("bfl1",     32'h0000_1000, 0, 0, 0, 0,  32'h0000_1004, 0,   1, 0,  S_FLUSH);
    br_target = 32'h2000;
    step("br2",      32'h0000_1004, 0, 1, 0, 0,  32'h0000_2000, 0,   1, 0,  S_FLUSH);
    step("bfl2",     32'h0000_2000, 0, 0, 0, 0,  32'h0000_2004, 0,   1, 0,  S_FLUSH);
    step("bfl3",     32'h0000_2004, 0, 0, 0, 0,  32'h0000_2008, 0,   1, 0,  S_FLUSH);
    step("brun",     32'h0000_2008, 0, 0, 0, 0,  32'h0000_200C, 0,   0, 0,  S_RUN);

    step("wrap",     32'hFFFF_FFFC, 0, 0, 0, 0,  32'h0000_0000, 0,   0, 0,  S_RUN);
    jump_target = 32'h0000_0013;
    step("mis",      32'h0000_0000, 0, 0, 1, 0,  32'h0000_0010, 0,   1, 0,  S_RUN);
    step("mfl1",     32'h0000_0010, 0, 0, 0, 0,  32'h0000_0014, 0,   1, 1,  S_FLUSH);
    step("mfl2",     32'h0000_0014, 1, 0, 0, 0,  32'h0000_0014, 1,   1, 1,  S_FLUSH);
    step("mrun",     32'h0000_0014, 0, 0, 0, 0,  32'h0000_0018, 0,   0, 1,  S_RUN);
    br_target = 32'h3000;
    step("br3",      32'h0000_0018, 0, 1, 0, 0,  32'h0000_3000, 0,   1, 1,  S_RUN);
    step("rfl1",     32'h0000_3000, 0, 0, 0, 0,  32'h0000_3004, 0,   1, 1,  S_FLUSH);

    // Mid-FLUSH, drop reset between edges with a redirect pending on the inputs.
    pc_cur = 32'h3004; jr = 1'b1; jr_target = 32'h7777;
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    @(posedge clk); #1;
    chk_reset("arst_hold");
    rst_n = 1'b1;
    step("boot2",    32'h0000_3004, 0, 0, 0, 1,  32'h0000_0100, 0,   1, 0,  S_BOOT);
    step("seq2",     32'h0000_0100, 0, 0, 0, 0,  32'h0000_0104, 0,   0, 0,  S_RUN);

    @(negedge clk); #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
